// File: rtl/lfsr_rng.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_rng
// Brief    : Fibonacci LFSR random source; request/response handshake with
//            rejection sampling into [0, RANGE-1].
// Revision : 1.0
// ============================================================================
module lfsr_rng #(
    parameter int  WIDTH     = 9,
    parameter int  SEED      = 1,
    parameter int  RANGE     = 10,
    parameter int  MAX_TRIES = 8,
    localparam int OUT_W     = $clog2(RANGE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             free_run,
    input  logic             req,
    output logic             req_ready,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic [OUT_W-1:0] rnd_data,
    output logic             rnd_fallback,
    output logic [WIDTH-1:0] lfsr_state
);

    generate
        if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
            $error("lfsr_rng: WIDTH must be in 3..16");
        end
        if (SEED < 1 || SEED >= (1 << WIDTH)) begin : g_bad_seed
            $error("lfsr_rng: SEED must be nonzero and fit in WIDTH");
        end
        if (RANGE < 2 || RANGE > (1 << WIDTH)) begin : g_bad_range
            $error("lfsr_rng: RANGE must be in 2..2^WIDTH");
        end
        if (MAX_TRIES < 1) begin : g_bad_tries
            $error("lfsr_rng: MAX_TRIES must be at least 1");
        end
    endgenerate

    // Tap i (1-indexed) maps to mask bit i-1.
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam int                 c_TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [15:0]        c_TAPS     = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0]   c_SEED     = WIDTH'(SEED);
    localparam logic [OUT_W:0]     c_RANGE    = (OUT_W + 1)'(RANGE);
    localparam logic [c_TRY_W-1:0] c_LAST_TRY = c_TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_fsm;
    state_t             w_fsm_nxt;
    logic [WIDTH-1:0]   r_lfsr;
    logic [WIDTH-1:0]   w_lfsr_nxt;
    logic [c_TRY_W-1:0] r_tries;
    logic [c_TRY_W-1:0] w_tries_nxt;
    logic [OUT_W-1:0]   r_data;
    logic [OUT_W-1:0]   w_data_nxt;
    logic               r_fallback;
    logic               w_fallback_nxt;

    logic               w_fb;
    logic [WIDTH-1:0]   w_step;
    logic [OUT_W-1:0]   w_cand;
    logic               w_cand_ok;
    logic [OUT_W-1:0]   w_fold;

    assign w_fb      = ^(r_lfsr & c_TAPS[WIDTH-1:0]);
    assign w_step    = {r_lfsr[WIDTH-2:0], w_fb};
    assign w_cand    = w_step[OUT_W-1:0];
    assign w_cand_ok = ({1'b0, w_cand} < c_RANGE);
    // Only used when cand >= RANGE; 2^OUT_W < 2*RANGE keeps the result in range.
    assign w_fold    = w_cand - c_RANGE[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm      <= S_IDLE;
            r_lfsr     <= c_SEED;
            r_tries    <= '0;
            r_data     <= '0;
            r_fallback <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_tries    <= w_tries_nxt;
            r_data     <= w_data_nxt;
            r_fallback <= w_fallback_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_lfsr_nxt     = r_lfsr;
        w_tries_nxt    = r_tries;
        w_data_nxt     = r_data;
        w_fallback_nxt = r_fallback;

        if (seed_load) begin
            // A zero seed would lock the register up, so substitute SEED.
            w_fsm_nxt   = S_IDLE;
            w_lfsr_nxt  = (seed_in == '0) ? c_SEED : seed_in;
            w_tries_nxt = '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (req) begin
                        w_fsm_nxt   = S_DRAW;
                        w_tries_nxt = '0;
                    end else if (free_run) begin
                        w_lfsr_nxt = w_step;
                    end
                end
                S_DRAW: begin
                    w_lfsr_nxt = w_step;
                    if (w_cand_ok) begin
                        w_data_nxt     = w_cand;
                        w_fallback_nxt = 1'b0;
                        w_fsm_nxt      = S_HOLD;
                    end else if (r_tries == c_LAST_TRY) begin
                        w_data_nxt     = w_fold;
                        w_fallback_nxt = 1'b1;
                        w_fsm_nxt      = S_HOLD;
                    end else begin
                        w_tries_nxt = r_tries + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (rnd_ready) begin
                        w_fsm_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_fsm_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (r_fsm == S_IDLE);
    assign rnd_valid    = (r_fsm == S_HOLD);
    assign rnd_data     = r_data;
    assign rnd_fallback = r_fallback;
    assign lfsr_state   = r_lfsr;

endmodule
`default_nettype wire
